// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared character codes and segment table for sevenseg_scroll
package sevenseg_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CH_H       = 5'd16;
    localparam logic [CODE_W-1:0] CH_L       = 5'd17;
    localparam logic [CODE_W-1:0] CH_O       = 5'd18;
    localparam logic [CODE_W-1:0] CH_P       = 5'd19;
    localparam logic [CODE_W-1:0] CH_U       = 5'd20;
    localparam logic [CODE_W-1:0] CH_R       = 5'd21;
    localparam logic [CODE_W-1:0] CH_N       = 5'd22;
    localparam logic [CODE_W-1:0] CH_DASH    = 5'd23;
    localparam logic [CODE_W-1:0] CH_UNDER   = 5'd24;
    localparam logic [CODE_W-1:0] CH_BLANK   = 5'd31;
    localparam logic [CODE_W-1:0] GLYPH_LAST = CH_UNDER;

    // Active-high {a,b,c,d,e,f,g} patterns indexed by character code; codes above GLYPH_LAST are blank.
    localparam logic [6:0] SEG_TABLE [0:24] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
        7'h37, 7'h0E, 7'h1D, 7'h67, 7'h3E, 7'h05, 7'h15, 7'h01,
        7'h08
    };

endpackage

// File: rtl/sevenseg_decode.sv
// rtl/sevenseg_decode.sv - combinational character code to active-high segment lookup
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [6:0]        o_seg
);

    always_comb begin
        o_seg = 7'h00;
        if (i_code <= GLYPH_LAST) begin
            o_seg = SEG_TABLE[i_code];
        end
    end

endmodule

// File: rtl/sevenseg_scroll.sv
// rtl/sevenseg_scroll.sv - multiplexed seven-segment message display
// Scrolling is built only when SEVENSEG_SCROLL_EN is defined; otherwise a static window is shown.
module sevenseg_scroll
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MSG_LEN        = 16,
    parameter int REFRESH_DIV    = 12000,
    parameter int SCROLL_DIV     = 48,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
    input  logic [CODE_W-1:0]            wr_data,
    input  logic [$clog2(MSG_LEN):0]     msg_len,
    output logic [6:0]                   seg,
    output logic [NUM_DIGITS-1:0]        dig_sel,
    output logic                         frame_tick
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int SW = LW + 3;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [RW-1:0]         REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]         DIG_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0]         ND_S     = SW'(NUM_DIGITS);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CODE_W-1:0]     r_mem [MSG_LEN];
    logic [RW-1:0]         r_refresh;
    logic [DW-1:0]         r_digit;
    logic [DW-1:0]         r_show_idx;
    logic                  r_upd;
    logic [AW-1:0]         r_addr;
    logic                  r_blank;
    logic                  r_frame_tick;
    logic [LW-1:0]         r_len_prev;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    logic                  w_tc;
    logic                  w_last_digit;
    logic [LW-1:0]         w_len;
    logic [SW-1:0]         w_len_s;
    logic [AW-1:0]         w_offset;
    logic [SW-1:0]         w_sum;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_blank;
    logic [6:0]            w_seg_raw;
    logic [6:0]            w_seg_on;
    logic [NUM_DIGITS-1:0] w_dig_oh;

    assign w_tc         = enable && (r_refresh == REF_LAST);
    assign w_last_digit = (r_digit == DIG_LAST);
    assign w_len        = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;
    assign w_len_s      = SW'(w_len);

    // offset < L and digit < NUM_DIGITS < L whenever scrolling, so one subtraction completes the modulo
    assign w_sum     = SW'(w_offset) + SW'(r_digit);
    assign w_rd_addr = AW'((w_sum >= w_len_s) ? (w_sum - w_len_s) : w_sum);
    assign w_blank   = (w_len_s == '0) || (SW'(r_digit) >= w_len_s);

`ifdef SEVENSEG_SCROLL_EN
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(SCROLL_DIV - 1);

    logic [FW-1:0] r_frame_cnt;
    logic [AW-1:0] r_offset;
    logic [SW-1:0] w_off_inc;

    assign w_off_inc = SW'(r_offset) + SW'(1);
    assign w_offset  = r_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_offset    <= '0;
        end else if ((msg_len != r_len_prev) || (w_len_s <= ND_S)) begin
            r_offset <= '0;
        end else if (w_tc && w_last_digit) begin
            if (r_frame_cnt == FR_LAST) begin
                r_frame_cnt <= '0;
                r_offset    <= (w_off_inc >= w_len_s) ? '0 : AW'(w_off_inc);
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end
`else
    assign w_offset = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_mem[i] <= CH_BLANK;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LW'(MSG_LEN))) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    sevenseg_decode u_decode (
        .i_code (r_mem[r_addr]),
        .o_seg  (w_seg_raw)
    );

    assign w_seg_on = r_blank ? 7'h00 : w_seg_raw;
    assign w_dig_oh = NUM_DIGITS'(1) << r_show_idx;

    // Character address is captured at the terminal count and the memory is read one cycle later,
    // so a write landing on the update edge still shows the old character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh    <= '0;
            r_digit      <= '0;
            r_show_idx   <= '0;
            r_upd        <= 1'b0;
            r_addr       <= '0;
            r_blank      <= 1'b1;
            r_frame_tick <= 1'b0;
            r_len_prev   <= '0;
            r_seg        <= SEG_OFF;
            r_dig        <= DIG_OFF;
        end else begin
            r_frame_tick <= w_tc && w_last_digit;
            r_len_prev   <= msg_len;
            if (enable) begin
                r_upd <= w_tc;
                if (w_tc) begin
                    r_refresh  <= '0;
                    r_digit    <= w_last_digit ? '0 : r_digit + DW'(1);
                    r_show_idx <= r_digit;
                    r_addr     <= w_rd_addr;
                    r_blank    <= w_blank;
                end else begin
                    r_refresh <= r_refresh + RW'(1);
                end
                if (r_upd) begin
                    r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
                    r_dig <= (DIG_ACTIVE_LOW != 0) ? ~w_dig_oh : w_dig_oh;
                end
            end else begin
                r_seg <= SEG_OFF;
                r_dig <= DIG_OFF;
            end
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig;
    assign frame_tick = r_frame_tick;

endmodule
